display_scan_sched: RTL and testbench

//  Time-multiplexed scan scheduler for the 4-digit, common-anode 7-segment display.
//  - Owns the shared SEG bus and steps digit enables 0->1->2->3->0.
//  - Inserts a dead-time blank between digits (anti-ghosting) and applies 8-level brightness.
//  - Takes frame data over a valid/ready port; updates only at frame boundaries (no tearing).

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/disp_seg_decode.sv | 19 +
 rtl/display_scan_sched.sv | 174 +++++++++++++++++
 tb/tb_display_scan_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 7-segment scan scheduler:
//   state_t    per-slot scan phase (dead-time blank, lit, post-lit dark)
//   SEG_BLANK  all segments off (active-low)
//   DIG_OFF    all digit enables off (active-low)
//   glyph()    hex nibble -> active-low segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic [1:0] {
      S_DEAD = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] DIG_OFF   = 4'hF;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/disp_seg_decode.sv
// ---------------------------------------------------------------------------
// disp_seg_decode
// Combinational nibble-to-segment decoder with a blank override.
// Ports:
//   nib_i    hex digit to show
//   blank_i  1 = force all segments dark
//   seg_o    active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module disp_seg_decode
   import disp_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   assign seg_o = blank_i ? SEG_BLANK : glyph(nib_i);

endmodule

// File: rtl/display_scan_sched.sv
// ---------------------------------------------------------------------------
// display_scan_sched
// Time-multiplexed scan scheduler for a 4-digit common-anode 7-segment display.
// Each digit slot is SLOT_CYC clocks: a dead-time blank, a lit window sized by
// BRIGHT, then a dark remainder. Frame data arrives over a valid/ready port and
// is held in a pending register until the end of the frame, so a frame is
// never shown half-old/half-new.
// Ports:
//   CLOCK_50MHZ  clock (rising edge)        RESET      sync active-high reset
//   WR_VALID     frame write request        WR_READY   pending slot free
//   WR_DATA      4 hex nibbles, [3:0]=digit0
//   BRIGHT       lit fraction (BRIGHT+1)/8  BLANK_EN   1 = all digits dark
//   DIG          active-low digit enables   SEG        active-low {g..a}
//   FRAME_DONE   pulse on last cycle of the digit-3 slot
// Build option: define DISP_LZ_BLANK_EN to blank leading zeros (digit 0 is
// always shown).
// ---------------------------------------------------------------------------
module display_scan_sched
   import disp_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int SCAN_HZ     = 1000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic        CLOCK_50MHZ,
   input  logic        RESET,
   input  logic        WR_VALID,
   output logic        WR_READY,
   input  logic [15:0] WR_DATA,
   input  logic [2:0]  BRIGHT,
   input  logic        BLANK_EN,
   output logic [3:0]  DIG,
   output logic [6:0]  SEG,
   output logic        FRAME_DONE
);

   localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
   localparam int ON_CYC   = SLOT_CYC - DEAD_CYCLES;
   localparam int CW       = $clog2(SLOT_CYC);

   function automatic int lit_cycles(input logic [2:0] b);
      return ((int'(b) + 1) * ON_CYC) >> 3;
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [2:0]      bright_q, bright_eff;
   logic            blank_q, blank_eff;
   logic [15:0]     active_q, pend_q;
   logic            pend_full_q;
   logic [3:0]      dig_q, dig_d;
   logic [6:0]      seg_q, seg_d;
   logic            fdone_q, fdone_d;
   logic            first_dead, slot_last, on_d, lz_dark;
   logic            accept, commit;
   logic [3:0]      nib_d;
   int              lit_end;

   assign WR_READY   = ~pend_full_q & ~RESET;
   assign accept     = WR_VALID & WR_READY;
   assign commit     = fdone_q & pend_full_q;
   assign DIG        = dig_q;
   assign SEG        = seg_q;
   assign FRAME_DONE = fdone_q;

   // Slot sequencing. The counter runs across the whole slot and is only
   // cleared when the FSM moves to the next digit's dead time.
   always_comb begin
      // BRIGHT/BLANK_EN are latched on the first dead cycle; use the live
      // value on that cycle so a one-cycle dead time still sees it.
      first_dead = (state_q == S_DEAD) && (cnt_q == '0);
      bright_eff = first_dead ? BRIGHT : bright_q;
      blank_eff  = first_dead ? BLANK_EN : blank_q;
      lit_end    = DEAD_CYCLES + lit_cycles(bright_eff);
      slot_last  = (int'(cnt_q) == SLOT_CYC - 1);
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      idx_d      = idx_q;
      case (state_q)
         S_DEAD: begin
            if (int'(cnt_q) == DEAD_CYCLES - 1) state_d = S_ON;
         end
         S_ON: begin
            if (int'(cnt_q) == lit_end - 1) begin
               if (slot_last) begin
                  // Full brightness: no dark remainder, go straight on.
                  state_d = S_DEAD;
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
               end else begin
                  state_d = S_OFF;
               end
            end
         end
         S_OFF: begin
            if (slot_last) begin
               state_d = S_DEAD;
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
            end
         end
         default: begin
            state_d = S_DEAD;
            cnt_d   = '0;
         end
      endcase
      // Outputs are computed from the next state so the registered pins line
      // up with the FSM phase they describe.
      fdone_d = (idx_d == 2'd3) && (int'(cnt_d) == SLOT_CYC - 1);
      nib_d   = active_q[{idx_d, 2'b00} +: 4];
   end

`ifdef DISP_LZ_BLANK_EN
   // A digit is a leading zero when it and every higher nibble are zero.
   always_comb begin
      case (idx_d)
         2'd3:    lz_dark = (active_q[15:12] == 4'h0);
         2'd2:    lz_dark = (active_q[15:8]  == 8'h00);
         2'd1:    lz_dark = (active_q[15:4]  == 12'h000);
         default: lz_dark = 1'b0;
      endcase
   end
`else
   assign lz_dark = 1'b0;
`endif

   assign on_d  = (state_d == S_ON) & ~blank_eff & ~lz_dark;
   assign dig_d = on_d ? ~(4'b0001 << idx_d) : DIG_OFF;

   disp_seg_decode u_dec (
      .nib_i   (nib_d),
      .blank_i (~on_d),
      .seg_o   (seg_d)
   );

   always_ff @(posedge CLOCK_50MHZ) begin
      if (RESET) begin
         state_q     <= S_DEAD;
         cnt_q       <= '0;
         idx_q       <= '0;
         bright_q    <= '0;
         blank_q     <= 1'b0;
         active_q    <= '0;
         pend_full_q <= 1'b0;
         dig_q       <= DIG_OFF;
         seg_q       <= SEG_BLANK;
         fdone_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         fdone_q <= fdone_d;
         if (first_dead) begin
            bright_q <= BRIGHT;
            blank_q  <= BLANK_EN;
         end
         // Commit and accept are exclusive: WR_READY is low while pending is full.
         if (commit) begin
            active_q    <= pend_q;
            pend_full_q <= 1'b0;
         end else if (accept) begin
            pend_full_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50MHZ) begin
      if (accept) pend_q <= WR_DATA;
   end

endmodule

// File: tb/tb_display_scan_sched.sv
module tb_display_scan_sched;

   localparam int CLK_HZ  = 1000;
   localparam int SCAN_HZ = 100;
   localparam int DEAD    = 2;
   localparam int SLOT    = CLK_HZ / SCAN_HZ;
   localparam int ONC     = SLOT - DEAD;
`ifdef DISP_LZ_BLANK_EN
   localparam bit LZ_ON = 1'b1;
`else
   localparam bit LZ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        RESET = 1'b1;
   logic        WR_VALID = 1'b0;
   logic        WR_READY;
   logic [15:0] WR_DATA = 16'h0;
   logic [2:0]  BRIGHT = 3'd7;
   logic        BLANK_EN = 1'b0;
   logic [3:0]  DIG;
   logic [6:0]  SEG;
   logic        FRAME_DONE;

   always #5 clk = ~clk;

   display_scan_sched #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEAD_CYCLES(DEAD)) dut (
      .CLOCK_50MHZ (clk),
      .RESET       (RESET),
      .WR_VALID    (WR_VALID),
      .WR_READY    (WR_READY),
      .WR_DATA     (WR_DATA),
      .BRIGHT      (BRIGHT),
      .BLANK_EN    (BLANK_EN),
      .DIG         (DIG),
      .SEG         (SEG),
      .FRAME_DONE  (FRAME_DONE)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: position within slot, digit index, buffers.
   int          m_pos = 0;
   int          m_idx = 0;
   logic [15:0] m_act = 16'h0;
   logic [15:0] m_pend = 16'h0;
   bit          m_full = 1'b0;
   bit          m_acc = 1'b0;
   logic [2:0]  m_bright = 3'd0;
   bit          m_blank = 1'b0;
   logic [3:0]  e_dig = 4'hF;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_fd = 1'b0;

   logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic bit lz_dark(input int k);
      return LZ_ON && (k > 0) && ((m_act >> (4 * k)) == 16'h0);
   endfunction

   function automatic logic e_rdy();
      return !m_full && !RESET;
   endfunction

   // Advance one clock: update the model with the inputs seen at the edge,
   // then return on the falling edge where outputs are compared.
   task automatic tick();
      int lit;
      bit on;
      logic [3:0] nib;
      @(posedge clk);
      cyc++;
      m_acc = 1'b0;
      if (RESET) begin
         m_pos = 0; m_idx = 0; m_act = 16'h0; m_full = 1'b0;
         e_dig = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
      end else begin
         if (e_fd && m_full) begin
            m_act = m_pend; m_full = 1'b0;
         end else if (WR_VALID && !m_full) begin
            m_pend = WR_DATA; m_full = 1'b1; m_acc = 1'b1;
         end
         if (m_pos == 0) begin
            m_bright = BRIGHT; m_blank = BLANK_EN;
         end
         m_pos++;
         if (m_pos == SLOT) begin
            m_pos = 0; m_idx = (m_idx + 1) % 4;
         end
         lit = ((int'(m_bright) + 1) * ONC) >> 3;
         on = (m_pos >= DEAD) && (m_pos < DEAD + lit) && !m_blank && !lz_dark(m_idx);
         nib = m_act[4*m_idx +: 4];
         e_dig = on ? ~(4'b0001 << m_idx) : 4'hF;
         e_seg = on ? GLY[nib] : 7'h7F;
         e_fd = (m_idx == 3) && (m_pos == SLOT - 1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int cnt [4];
      RESET = 1'b1; WR_VALID = 1'b1; WR_DATA = 16'hFFFF; BRIGHT = 3'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (DIG !== 4'hF || SEG !== 7'h7F || WR_READY !== 1'b0 || FRAME_DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got DIG=%b SEG=%b RDY=%b FD=%b want 1111 1111111 0 0", cyc, DIG, SEG, WR_READY, FRAME_DONE);
         end
      end
      WR_VALID = 1'b0; RESET = 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL reset_scan cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         if (i == 0) begin
            n_chk++;
            if (DIG !== 4'hF) begin
               n_fail++;
               $display("FAIL reset_dead cyc=%0d got DIG=%b want 1111", cyc, DIG);
            end
         end
         for (int k = 0; k < 4; k++)
            if (DIG === ~(4'b0001 << k) && SEG === 7'b1000000) cnt[k]++;
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (cnt[k] != 8) begin
            n_fail++;
            $display("FAIL reset_zero_digit%0d got %0d lit cycles want 8", k, cnt[k]);
         end
      end
   endtask

   task automatic test_write();
      bit found;
      int cnt [4];
      logic [6:0] want [4];
      want[0] = 7'b0010010; want[1] = 7'b0110000; want[2] = 7'b0100100; want[3] = 7'b1111001;
      BRIGHT = 3'd7; WR_DATA = 16'h1235; WR_VALID = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (m_acc) found = 1'b1;
      end
      WR_VALID = 1'b0;
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL write_accept timeout"); end
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL write_wait cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         if (FRAME_DONE === 1'b1) found = 1'b1;
         else tick();
      end
      n_chk++;
      if (!found || WR_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL write_ready_at_fd found=%0d got RDY=%b want 0", found, WR_READY);
      end
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 0) begin
            n_chk++;
            if (WR_READY !== 1'b1) begin
               n_fail++;
               $display("FAIL write_ready_after_fd got %b want 1", WR_READY);
            end
         end
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL write_frame cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         for (int k = 0; k < 4; k++)
            if (DIG === ~(4'b0001 << k) && SEG === want[k]) cnt[k]++;
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (cnt[k] != 8) begin
            n_fail++;
            $display("FAIL write_digit%0d got %0d cycles want 8", k, cnt[k]);
         end
      end
   endtask

   task automatic test_bright0();
      bit found;
      int n, lit;
      BRIGHT = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      n = 0; lit = 0; found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         n++;
         if (DIG !== 4'hF) lit++;
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL bright0_scan cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      n_chk++;
      if (n != 40 || lit != 4) begin
         n_fail++;
         $display("FAIL bright0_period got period=%0d lit=%0d want 40 4", n, lit);
      end
   endtask

   task automatic test_hold();
      bit found, prev_fd;
      BRIGHT = 3'd7;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      repeat (15) tick();
      WR_DATA = 16'h1111; WR_VALID = 1'b1;
      tick();
      n_chk++;
      if (!m_acc || WR_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_first_accept got RDY=%b want 0 after accept", WR_READY);
      end
      WR_DATA = 16'h2222;
      found = 1'b0; prev_fd = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         prev_fd = FRAME_DONE;
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL hold_wait cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         if (m_acc) found = 1'b1;
      end
      WR_VALID = 1'b0;
      n_chk++;
      if (!found || prev_fd !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_second_accept found=%0d prev_fd=%b want 1 0", found, prev_fd);
      end
      for (int i = 0; i < 90; i++) begin
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL hold_frames cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      int lit, bad;
      BRIGHT = 3'd7;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      WR_DATA = 16'hABCD; WR_VALID = 1'b1;
      tick();
      WR_VALID = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (DIG === 4'b1011) found = 1'b1;
      end
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL rstmid_digit2 timeout"); end
      RESET = 1'b1;
      tick();
      n_chk++;
      if (DIG !== 4'hF || SEG !== 7'h7F || WR_READY !== 1'b0 || FRAME_DONE !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_blank got DIG=%b SEG=%b RDY=%b FD=%b want 1111 1111111 0 0", DIG, SEG, WR_READY, FRAME_DONE);
      end
      RESET = 1'b0;
      lit = 0; bad = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL rstmid_resume cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         if (i >= 1 && i <= 8 && DIG === 4'b1110) lit++;
         if (DIG !== 4'hF && SEG !== 7'b1000000) bad++;
      end
      n_chk++;
      if (lit != 8 || bad != 0) begin
         n_fail++;
         $display("FAIL rstmid_zeros got digit0_lit=%0d nonzero_glyphs=%0d want 8 0", lit, bad);
      end
   endtask

   task automatic test_lz();
      bit found;
      int cnt [4];
      int lit, fds;
      logic [6:0] want [4];
      want[0] = 7'b1000000; want[1] = 7'b1111000; want[2] = 7'b1000000; want[3] = 7'b1000000;
      BRIGHT = 3'd7; BLANK_EN = 1'b0;
      WR_DATA = 16'h0070; WR_VALID = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (m_acc) found = 1'b1;
      end
      WR_VALID = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      n_chk++;
      if (!found) begin n_fail++; $display("FAIL lz_commit timeout"); end
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL lz_frame cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
         for (int k = 0; k < 4; k++)
            if (DIG === ~(4'b0001 << k) && SEG === want[k]) cnt[k]++;
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (cnt[k] != ((LZ_ON && k >= 2) ? 0 : 8)) begin
            n_fail++;
            $display("FAIL lz_digit%0d got %0d lit cycles want %0d", k, cnt[k], (LZ_ON && k >= 2) ? 0 : 8);
         end
      end
      BLANK_EN = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (FRAME_DONE === 1'b1) found = 1'b1;
      end
      lit = 0; fds = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (DIG !== 4'hF || SEG !== 7'h7F) lit++;
         if (FRAME_DONE === 1'b1) fds++;
      end
      n_chk++;
      if (lit != 0 || fds != 1) begin
         n_fail++;
         $display("FAIL blank_en got lit=%0d frame_done=%0d want 0 1", lit, fds);
      end
      BLANK_EN = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         WR_VALID = ($urandom_range(0, 2) == 0);
         WR_DATA  = 16'($urandom);
         if ($urandom_range(0, 15) == 0) BRIGHT = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0) BLANK_EN = ~BLANK_EN;
         RESET = ($urandom_range(0, 299) == 0);
         tick();
         n_chk++;
         if ({DIG, SEG, FRAME_DONE, WR_READY} !== {e_dig, e_seg, e_fd, e_rdy()}) begin
            n_fail++;
            $display("FAIL random cyc=%0d got %b %b %b %b want %b %b %b %b", cyc, DIG, SEG, FRAME_DONE, WR_READY, e_dig, e_seg, e_fd, e_rdy());
         end
      end
      RESET = 1'b0; WR_VALID = 1'b0; BLANK_EN = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_bright0();
      test_hold();
      test_reset_mid();
      test_lz();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
